// File: rtl/ahb_master_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter: per-master pending address registers,
// one grant per downstream address phase, losing masters stalled through their own hready.
module ahb_master_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [2*ADDR_WIDTH-1:0] m_haddr,
    input  logic [2*DATA_WIDTH-1:0] m_hwdata,
    output logic [2*DATA_WIDTH-1:0] m_hrdata,
    input  logic [1:0]              m_hwrite,
    input  logic [3:0]              m_htrans,
    input  logic [5:0]              m_hsize,
    input  logic [5:0]              m_hburst,
    input  logic [7:0]              m_hprot,
    input  logic [1:0]              m_hmastlock,
    output logic [1:0]              m_hready,
    output logic [1:0]              m_hresp,
    output logic [ADDR_WIDTH-1:0]   s_haddr,
    output logic                    s_hwrite,
    output logic [1:0]              s_htrans,
    output logic [2:0]              s_hsize,
    output logic [2:0]              s_hburst,
    output logic [3:0]              s_hprot,
    output logic                    s_hmastlock,
    output logic                    s_hsel,
    output logic [DATA_WIDTH-1:0]   s_hwdata,
    input  logic [DATA_WIDTH-1:0]   s_hrdata,
    input  logic                    s_hready,
    input  logic                    s_hresp
);

    // Address stage (p0): captured master address phases waiting for the slave
    logic [1:0]            r_vld_p0;
    logic [ADDR_WIDTH-1:0] r_addr_p0  [2];
    logic [1:0]            r_write_p0;
    logic [1:0]            r_trans_p0 [2];
    logic [2:0]            r_size_p0  [2];
    logic [2:0]            r_burst_p0 [2];
    logic [3:0]            r_prot_p0  [2];
    logic [1:0]            r_lock_p0;

    // Data stage (p1): which master owns the downstream data phase
    logic                  r_vld_p1;
    logic                  r_owner_p1;

    logic                  r_last_grant;
    logic                  r_lock_vld;
    logic                  r_lock_owner;

    logic [1:0]            w_owns;
    logic [1:0]            w_hready;
    logic [1:0]            w_capture;
    logic [1:0]            w_cand;
    logic [1:0]            w_clr;
    logic                  w_gnt_vld;
    logic                  w_gnt;
    logic                  w_accept;
    logic                  w_lock_release;

    always_comb begin
        w_owns    = '0;
        w_hready  = '0;
        w_capture = '0;
        for (int i = 0; i < 2; i++) begin
            w_owns[i]    = r_vld_p1 & (r_owner_p1 == 1'(i));
            w_hready[i]  = ~r_vld_p0[i] & (~w_owns[i] | s_hready);
            w_capture[i] = m_htrans[2*i+1] & w_hready[i];
        end
        w_lock_release = r_lock_vld & ~m_hmastlock[r_lock_owner] & w_hready[r_lock_owner];
    end

    // A held lock masks the other master out of arbitration entirely.
    always_comb begin
        w_cand = r_vld_p0;
        if (r_lock_vld) begin
            w_cand = r_vld_p0 & (r_lock_owner ? 2'b10 : 2'b01);
        end
        w_gnt_vld = |w_cand;
        if (&w_cand) begin
            w_gnt = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b1;
        end else begin
            w_gnt = w_cand[1];
        end
        w_accept = w_gnt_vld & s_hready;
        w_clr    = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_vld_p0     <= '0;
            r_vld_p1     <= 1'b0;
            r_owner_p1   <= 1'b0;
            r_last_grant <= 1'b0;
            r_lock_vld   <= 1'b0;
            r_lock_owner <= 1'b0;
        end else begin
            r_vld_p0 <= (r_vld_p0 & ~w_clr) | w_capture;
            if (w_lock_release) begin
                r_lock_vld <= 1'b0;
            end
            if (w_accept) begin
                r_last_grant <= w_gnt;
                r_vld_p1     <= 1'b1;
                r_owner_p1   <= w_gnt;
                if (r_lock_p0[w_gnt]) begin
                    r_lock_vld   <= 1'b1;
                    r_lock_owner <= w_gnt;
                end
            end else if (s_hready) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (w_capture[i]) begin
                r_addr_p0[i]  <= m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_write_p0[i] <= m_hwrite[i];
                r_trans_p0[i] <= m_htrans[2*i +: 2];
                r_size_p0[i]  <= m_hsize[3*i +: 3];
                r_burst_p0[i] <= m_hburst[3*i +: 3];
                r_prot_p0[i]  <= m_hprot[4*i +: 4];
                r_lock_p0[i]  <= m_hmastlock[i];
            end
        end
    end

    always_comb begin
        s_haddr     = '0;
        s_hwrite    = 1'b0;
        s_htrans    = 2'b00;
        s_hsize     = '0;
        s_hburst    = '0;
        s_hprot     = '0;
        s_hmastlock = 1'b0;
        s_hsel      = 1'b0;
        if (w_gnt_vld) begin
            s_haddr     = r_addr_p0[w_gnt];
            s_hwrite    = r_write_p0[w_gnt];
            s_htrans    = r_trans_p0[w_gnt];
            s_hsize     = r_size_p0[w_gnt];
            s_hburst    = r_burst_p0[w_gnt];
            s_hprot     = r_prot_p0[w_gnt];
            s_hmastlock = r_lock_p0[w_gnt];
            s_hsel      = 1'b1;
        end
        s_hwdata = '0;
        if (r_vld_p1) begin
            s_hwdata = r_owner_p1 ? m_hwdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_hwdata[DATA_WIDTH-1:0];
        end
        m_hresp  = w_owns & {2{s_hresp}};
        m_hready = w_hready;
        m_hrdata = {2{s_hrdata}};
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: round-robin and fixed-priority instances share stimulus,
// checked each cycle against a transaction-level model plus hand-computed expectations.
module tb_ahb_master_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [63:0] m_haddr, m_hwdata;
    logic [1:0]  m_hwrite, m_hmastlock;
    logic [3:0]  m_htrans;
    logic [5:0]  m_hsize, m_hburst;
    logic [7:0]  m_hprot;
    logic [31:0] s_hrdata;
    logic        s_hready, s_hresp;

    logic [63:0] m_hrdata_a, m_hrdata_b;
    logic [1:0]  m_hready_a, m_hready_b, m_hresp_a, m_hresp_b;
    logic [31:0] s_haddr_a, s_haddr_b, s_hwdata_a, s_hwdata_b;
    logic        s_hwrite_a, s_hwrite_b, s_hmastlock_a, s_hmastlock_b, s_hsel_a, s_hsel_b;
    logic [1:0]  s_htrans_a, s_htrans_b;
    logic [2:0]  s_hsize_a, s_hsize_b, s_hburst_a, s_hburst_b;
    logic [3:0]  s_hprot_a, s_hprot_b;

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .m_haddr(m_haddr), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata_a), .m_hwrite(m_hwrite), .m_htrans(m_htrans), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hmastlock(m_hmastlock),
        .m_hready(m_hready_a), .m_hresp(m_hresp_a), .s_haddr(s_haddr_a), .s_hwrite(s_hwrite_a),
        .s_htrans(s_htrans_a), .s_hsize(s_hsize_a), .s_hburst(s_hburst_a), .s_hprot(s_hprot_a),
        .s_hmastlock(s_hmastlock_a), .s_hsel(s_hsel_a), .s_hwdata(s_hwdata_a),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp));

    ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .m_haddr(m_haddr), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata_b), .m_hwrite(m_hwrite), .m_htrans(m_htrans), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hmastlock(m_hmastlock),
        .m_hready(m_hready_b), .m_hresp(m_hresp_b), .s_haddr(s_haddr_b), .s_hwrite(s_hwrite_b),
        .s_htrans(s_htrans_b), .s_hsize(s_hsize_b), .s_hburst(s_hburst_b), .s_hprot(s_hprot_b),
        .s_hmastlock(s_hmastlock_b), .s_hsel(s_hsel_b), .s_hwdata(s_hwdata_b),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp));

    logic [46:0] aph_a, aph_b;
    assign aph_a = {s_haddr_a, s_hwrite_a, s_htrans_a, s_hsize_a, s_hburst_a, s_hprot_a, s_hmastlock_a, s_hsel_a};
    assign aph_b = {s_haddr_b, s_hwrite_b, s_htrans_b, s_hsize_b, s_hburst_b, s_hprot_b, s_hmastlock_b, s_hsel_b};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, k, $time, act, exp);
        end
    endtask

    // Transaction-level model: index k=0 round-robin instance, k=1 fixed-priority instance.
    typedef struct {
        bit          v;
        logic [31:0] addr;
        bit          write;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        bit          lock;
    } req_t;

    req_t pend [2][2];
    int   dow  [2];
    int   last [2];
    int   lko  [2];

    function automatic int winner(int k);
        bit a, b;
        a = pend[k][0].v;
        b = pend[k][1].v;
        if (lko[k] >= 0) return pend[k][lko[k]].v ? lko[k] : -1;
        if (a && b) return (k == 0) ? 1 - last[k] : 1;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    function automatic bit ready_of(int k, int i);
        return !pend[k][i].v && (dow[k] != i || s_hready);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend[k][0].v = 1'b0;
            pend[k][1].v = 1'b0;
            dow[k]  = -1;
            last[k] = 0;
            lko[k]  = -1;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int w;
            bit rdy [2];
            w = winner(k);
            rdy[0] = ready_of(k, 0);
            rdy[1] = ready_of(k, 1);
            if (lko[k] >= 0 && !m_hmastlock[lko[k]] && rdy[lko[k]]) lko[k] = -1;
            if (w >= 0 && s_hready) begin
                if (pend[k][w].lock) lko[k] = w;
                pend[k][w].v = 1'b0;
                last[k] = w;
                dow[k]  = w;
            end else if (s_hready) begin
                dow[k] = -1;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_htrans[2*i+1] && rdy[i]) begin
                    pend[k][i].v     = 1'b1;
                    pend[k][i].addr  = m_haddr[i*32 +: 32];
                    pend[k][i].write = m_hwrite[i];
                    pend[k][i].trans = m_htrans[2*i +: 2];
                    pend[k][i].size  = m_hsize[3*i +: 3];
                    pend[k][i].burst = m_hburst[3*i +: 3];
                    pend[k][i].prot  = m_hprot[4*i +: 4];
                    pend[k][i].lock  = m_hmastlock[i];
                end
            end
        end
    endtask

    initial begin
        int          w;
        logic [46:0] e_aph;
        logic [1:0]  e_rdy, e_resp;
        logic [31:0] e_wd;
        model_reset();
        forever begin
            @(negedge HCLK);
            if (!HRESETn) model_reset();
            for (int k = 0; k < 2; k++) begin
                w = winner(k);
                e_aph = '0;
                if (w >= 0)
                    e_aph = {pend[k][w].addr, pend[k][w].write, pend[k][w].trans, pend[k][w].size,
                             pend[k][w].burst, pend[k][w].prot, pend[k][w].lock, 1'b1};
                e_rdy  = {ready_of(k, 1), ready_of(k, 0)};
                e_resp = {(dow[k] == 1) && s_hresp, (dow[k] == 0) && s_hresp};
                e_wd   = (dow[k] >= 0) ? m_hwdata[dow[k]*32 +: 32] : 32'h0;
                chk("aphase", k, (k == 0) ? aph_a : aph_b, e_aph);
                chk("hready", k, (k == 0) ? m_hready_a : m_hready_b, e_rdy);
                chk("hresp", k, (k == 0) ? m_hresp_a : m_hresp_b, e_resp);
                chk("hwdata", k, (k == 0) ? s_hwdata_a : s_hwdata_b, e_wd);
                chk("hrdata", k, (k == 0) ? m_hrdata_a : m_hrdata_b, {2{s_hrdata}});
            end
            if (HRESETn) model_step();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_all();
        m_htrans    = 4'b0000;
        m_hmastlock = 2'b00;
        m_hwrite    = 2'b00;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input bit wr, input bit lk);
        m_haddr[i*32 +: 32] = a;
        m_htrans[2*i +: 2]  = 2'b10;
        m_hwrite[i]         = wr;
        m_hmastlock[i]      = lk;
        m_hsize[3*i +: 3]   = 3'b010;
        m_hburst[3*i +: 3]  = 3'b000;
        m_hprot[4*i +: 4]   = 4'b0011;
    endtask

    task automatic do_reset();
        tick(1);
        HRESETn = 1'b0;
        tick(1);
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn  = 1'b0;
        idle_all();
        m_haddr  = '0;
        m_hwdata = '0;
        m_hsize  = '0;
        m_hburst = '0;
        m_hprot  = '0;
        s_hrdata = '0;
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        tick(2);
        settle();
        chk("rst_hready", 0, m_hready_a, 2'b11);
        chk("rst_hready", 1, m_hready_b, 2'b11);
        chk("rst_htrans", 0, s_htrans_a, 2'b00);
        chk("rst_hsel", 0, s_hsel_a, 1'b0);
        chk("rst_hresp", 0, m_hresp_a, 2'b00);
        tick(1);
        HRESETn = 1'b1;

        // single zero-wait read from m0
        tick(1);
        issue(0, 32'h100, 1'b0, 1'b0);
        s_hrdata = 32'hDEADBEEF;
        tick(1);
        idle_all();
        settle();
        chk("t1_htrans", 0, s_htrans_a, 2'b10);
        chk("t1_haddr", 0, s_haddr_a, 32'h100);
        chk("t1_hready0_wait", 0, m_hready_a[0], 1'b0);
        tick(1);
        settle();
        chk("t1_hready0_done", 0, m_hready_a[0], 1'b1);
        chk("t1_hrdata", 0, m_hrdata_a[31:0], 32'hDEADBEEF);

        // simultaneous request after reset: m1 wins, m0 waits one extra cycle
        do_reset();
        issue(0, 32'h200, 1'b0, 1'b0);
        issue(1, 32'h8000_0010, 1'b1, 1'b0);
        tick(1);
        idle_all();
        m_hwdata[63:32] = 32'h55AA;
        settle();
        chk("t2_first_haddr", 0, s_haddr_a, 32'h8000_0010);
        chk("t2_first_hwrite", 0, s_hwrite_a, 1'b1);
        chk("t2_hready_both_low", 0, m_hready_a, 2'b00);
        tick(1);
        settle();
        chk("t2_second_haddr", 0, s_haddr_a, 32'h200);
        chk("t2_hwdata", 0, s_hwdata_a, 32'h55AA);
        chk("t2_hready_m0_low", 0, m_hready_a, 2'b10);
        tick(1);
        settle();
        chk("t2_hready_done", 0, m_hready_a, 2'b11);

        // four back-to-back ties: fixed priority always picks m1
        do_reset();
        for (int r = 0; r < 4; r++) begin
            issue(0, 32'h200 + 32'(4*r), 1'b0, 1'b0);
            issue(1, 32'h8000_0010 + 32'(4*r), 1'b1, 1'b0);
            tick(1);
            idle_all();
            m_hwdata[63:32] = 32'h55AA + 32'(r);
            settle();
            chk("t3_tie_m1", 1, s_haddr_b, 32'h8000_0010 + 32'(4*r));
            tick(1);
            settle();
            chk("t3_then_m0", 1, s_haddr_b, 32'h200 + 32'(4*r));
            chk("t3_hwdata", 1, s_hwdata_b, 32'h55AA + 32'(r));
            tick(1);
        end
        // m1 served alone, then a tie: round-robin flips to m0, fixed priority stays on m1
        issue(1, 32'h8000_0100, 1'b0, 1'b0);
        tick(1);
        idle_all();
        tick(1);
        issue(0, 32'h210, 1'b0, 1'b0);
        issue(1, 32'h8000_0104, 1'b0, 1'b0);
        tick(1);
        idle_all();
        settle();
        chk("t3_rr_tie", 0, s_haddr_a, 32'h210);
        chk("t3_fp_tie", 1, s_haddr_b, 32'h8000_0104);
        tick(1);
        settle();
        chk("t3_rr_next", 0, s_haddr_a, 32'h8000_0104);
        chk("t3_fp_next", 1, s_haddr_b, 32'h210);
        tick(2);

        // locked pair from m1 blocks pending m0 until the lock drops
        do_reset();
        issue(0, 32'h300, 1'b0, 1'b0);
        issue(1, 32'h40, 1'b0, 1'b1);
        tick(1);
        m_htrans[1:0]  = 2'b00;
        m_haddr[63:32] = 32'h44;
        settle();
        chk("t4_lock_first", 0, s_haddr_a, 32'h40);
        chk("t4_lock_flag", 0, s_hmastlock_a, 1'b1);
        tick(1);
        settle();
        chk("t4_m0_blocked", 0, s_hsel_a, 1'b0);
        chk("t4_m0_stalled", 0, m_hready_a[0], 1'b0);
        tick(1);
        idle_all();
        settle();
        chk("t4_lock_second", 0, s_haddr_a, 32'h44);
        chk("t4_lock_flag2", 0, s_hmastlock_a, 1'b1);
        tick(1);
        settle();
        chk("t4_still_blocked", 0, s_hsel_a, 1'b0);
        tick(1);
        settle();
        chk("t4_m0_granted", 0, s_haddr_a, 32'h300);
        chk("t4_m0_nolock", 0, s_hmastlock_a, 1'b0);
        tick(2);

        // two slave wait states on an m0 read, then ERROR on its next transfer
        issue(0, 32'h400, 1'b0, 1'b0);
        tick(1);
        m_haddr[31:0] = 32'h404;
        settle();
        chk("t5_wait1", 0, m_hready_a[0], 1'b0);
        tick(1);
        s_hready = 1'b0;
        settle();
        chk("t5_wait2", 0, m_hready_a[0], 1'b0);
        tick(1);
        settle();
        chk("t5_wait3", 0, m_hready_a[0], 1'b0);
        tick(1);
        s_hready = 1'b1;
        s_hrdata = 32'hCAFE0001;
        settle();
        chk("t5_ready", 0, m_hready_a[0], 1'b1);
        chk("t5_hrdata", 0, m_hrdata_a[31:0], 32'hCAFE0001);
        tick(1);
        idle_all();
        settle();
        chk("t5_next_addr", 0, s_haddr_a, 32'h404);
        tick(1);
        s_hready = 1'b0;
        s_hresp  = 1'b1;
        settle();
        chk("t5_err1_resp", 0, m_hresp_a, 2'b01);
        chk("t5_err1_ready", 0, m_hready_a[0], 1'b0);
        tick(1);
        s_hready = 1'b1;
        settle();
        chk("t5_err2_resp", 0, m_hresp_a, 2'b01);
        chk("t5_err2_ready", 0, m_hready_a[0], 1'b1);
        tick(1);
        s_hresp = 1'b0;
        settle();
        chk("t5_resp_clear", 0, m_hresp_a, 2'b00);

        // reset during m1's data phase, then a fresh m0 read
        tick(1);
        issue(1, 32'h500, 1'b1, 1'b0);
        tick(1);
        idle_all();
        m_hwdata[63:32] = 32'h1234;
        tick(1);
        s_hready = 1'b0;
        #1;
        chk("t6_m1_stalled", 0, m_hready_a[1], 1'b0);
        chk("t6_m1_hwdata", 0, s_hwdata_a, 32'h1234);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("t6_rst_hready", 0, m_hready_a, 2'b11);
        chk("t6_rst_hready", 1, m_hready_b, 2'b11);
        chk("t6_rst_htrans", 0, s_htrans_a, 2'b00);
        chk("t6_rst_hsel", 0, s_hsel_a, 1'b0);
        tick(1);
        HRESETn  = 1'b1;
        s_hready = 1'b1;
        s_hrdata = 32'h0BAD_F00D;
        issue(0, 32'h600, 1'b0, 1'b0);
        tick(1);
        idle_all();
        settle();
        chk("t6_new_addr", 0, s_haddr_a, 32'h600);
        tick(1);
        settle();
        chk("t6_new_done", 0, m_hready_a, 2'b11);
        chk("t6_new_hrdata", 0, m_hrdata_a[31:0], 32'h0BAD_F00D);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Two-master to one-slave AHB-Lite arbiter. It lets the instruction-fetch port (master 0) and the load/store port (master 1) share a single AHB-Lite slave path, for example one unified memory or the AHB_Bus slave side.
- Each master's address phase is captured into a per-master pending register. The arbiter grants one pending request per downstream address phase.
- Losing or waiting masters are stalled through their own hready.

Parameters:
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width.
ROUND_ROBIN, 1, 1 = alternate grant on contention; 0 = master 1 has fixed priority.

Ports:
HCLK  input  1  clock.
HRESETn  input  1  reset; one clock, asynchronous, active-low.
m_haddr  input  2*ADDR_WIDTH  master address; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
m_hwdata  input  2*DATA_WIDTH  master write data.
m_hrdata  output  2*DATA_WIDTH  read data; both slices carry s_hrdata.
m_hwrite  input  2  per-master write.
m_htrans  input  4  per-master htrans (2 bits each).
m_hsize  input  6  per-master hsize.
m_hburst  input  6  per-master hburst.
m_hprot  input  8  per-master hprot.
m_hmastlock  input  2  per-master lock.
m_hready  output  2  per-master hready.
m_hresp  output  2  per-master hresp.
s_haddr, s_hwrite, s_htrans, s_hsize, s_hburst, s_hprot, s_hmastlock  output  single-master widths  downstream address phase.
s_hsel  output  1  downstream select.
s_hwdata  output  DATA_WIDTH  downstream write data.
s_hrdata  input  DATA_WIDTH  downstream read data.
s_hready  input  1  downstream ready.
s_hresp  input  1  downstream response.

Behaviour:
- **Capture.** Master i's address phase is captured when m_htrans[i][1]=1 and m_hready[i]=1 at a rising HCLK edge.
  - Captured fields: addr, write, trans, size, burst, prot, mastlock. pend_valid[i] is set.
  - IDLE and BUSY transfers are never captured.
- **Grant (combinational from registers).**
  - Candidates are i with pend_valid[i]=1. If only one candidate exists, it wins.
  - If both are candidates: with ROUND_ROBIN=1 the master not in last_grant wins; with ROUND_ROBIN=0 master 1 wins.
  - While lock_owner is valid, only lock_owner may be granted.
- **Downstream address phase.**
  - With a grant: s_* is driven from the granted pending register and s_hsel=1.
  - With no grant: s_htrans=00, s_hsel=0, s_hmastlock=0, and the other s_* fields are 0.
  - When a grant is present and s_hready=1: the address is accepted, pend_valid[g] clears, last_grant<=g, and the data-phase register becomes {dvalid=1, downer=g}.
  - Otherwise, when s_hready=1, dvalid<=0.
- **Data phase.**
  - s_hwdata = m_hwdata slice of downer. When dvalid=0, s_hwdata is 0.
  - m_hresp[i] = s_hresp when dvalid and downer==i; otherwise 0.
- **Master hready.**
  - m_hready[i] = ~pend_valid[i] & (~(dvalid & downer==i) | s_hready).
  - Zero-wait slave: the master sees exactly 1 wait state (capture T, downstream address T+1, m_hready high at T+2).
  - A master may issue its next address in the same cycle its data completes; that address is captured.
- **Lock.**
  - lock_owner<=g when a transfer with mastlock=1 is accepted.
  - It is cleared when m_hmastlock[owner]=0 while m_hready[owner]=1.
- **Reset values.** Reset clears pend_valid, dvalid, lock_owner, and last_grant (last_grant resets to 0, so master 1 wins the first tie with ROUND_ROBIN=1).
  - Outputs at reset: m_hready=2'b11, m_hresp=0, s_htrans=IDLE, s_hsel=0, all other s_* = 0.
- **Reset mid-transfer.** Reset taken mid-transfer drops all pending and in-flight state immediately (asynchronously). No replay after release.
- **ERROR response.**
  - The two-cycle ERROR response passes through to the owner unmodified.
  - A pending request from the same master is still issued; cancelling is the master's responsibility via IDLE on its next address.

Test Plan:
- Single read m0 addr 0x100, slave zero-wait, s_hrdata=0xDEADBEEF → s_htrans=NONSEQ at T+1 with s_haddr=0x100; m_hready[0]=0 at T+1, =1 at T+2; m_hrdata[31:0]=0xDEADBEEF.
- Simultaneous NONSEQ m0 0x200 and m1 write 0x8000_0010 of 0x55AA, ROUND_ROBIN=1, after reset → m1 granted first, s_hwdata=0x55AA; m0 granted the next cycle; m_hready[0] held low one extra cycle.
- Same stimulus with ROUND_ROBIN=0, repeated back-to-back 4 times → m1 wins every tie; m0 is serviced only in cycles where m1 is not pending.
- m1 locked pair (mastlock=1, addr 0x40 then 0x44) while m0 is pending → both m1 transfers are issued consecutively; m0 is granted only after m1 drops m_hmastlock.
- Slave inserts 2 wait states on m0 read, plus ERROR on the next transfer → m_hready[0] low 3 cycles, then m_hresp[0]=1 for 2 cycles; m_hresp[1] stays 0.
- Assert HRESETn=0 while m1 is in its data phase → same cycle: m_hready=11, s_htrans=00, s_hsel=0; after release, a new m0 request completes normally.
